// File: rtl/multi_symbol_order_book.sv
// Multi-instrument limit order book: serial SEARCH scan, APPLY, serial REBEST scan, then top-of-book publish.
// Define ORDER_BOOK_STATS_EN to compile the message/reject counters and per-side occupancy tracking.
package msob_pkg;
   localparam logic [2:0] MSG_ADD     = 3'd1;
   localparam logic [2:0] MSG_UPDATE  = 3'd2;
   localparam logic [2:0] MSG_DELETE  = 3'd3;
   localparam logic [2:0] MSG_EXECUTE = 3'd4;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [1:0]  side;      // 0 bid, 1 ask, anything else rejected
      logic [7:0]  symbol;
      logic [31:0] order_id;
      logic [31:0] price;
      logic [31:0] quantity;
   } parsed_msg_t;
endpackage

module multi_symbol_order_book
   import msob_pkg::*;
#(
   parameter int MAX_ORDERS  = 16,
   parameter int NUM_SYMBOLS = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          empty,
   input  parsed_msg_t                   parsed_message,
   output logic                          read_en,
   output logic                          busy,
   output logic                          tob_valid,
   output logic [7:0]                    tob_symbol,
   output logic [31:0]                   best_bid_price,
   output logic [31:0]                   best_ask_price,
   output logic [31:0]                   best_bid_quantity,
   output logic [31:0]                   best_ask_quantity,
   output logic                          bid_present,
   output logic                          ask_present,
   output logic                          err_valid,
   output logic [2:0]                    err_code,
   output logic [31:0]                   msg_count,
   output logic [31:0]                   reject_count,
   output logic [$clog2(MAX_ORDERS):0]   bid_occupancy,
   output logic [$clog2(MAX_ORDERS):0]   ask_occupancy
);
   localparam int IW = $clog2(MAX_ORDERS);
   localparam int OW = IW + 1;
   localparam int SW = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
   localparam logic [IW-1:0] LAST = IW'(MAX_ORDERS - 1);

   typedef enum logic [2:0] {IDLE, SEARCH, APPLY, REBEST, PUBLISH} state_t;
   state_t r_state, w_next;

   logic [2:0]  r_type;
   logic        r_side;
   logic [7:0]  r_sym;
   logic [31:0] r_id, r_price, r_qty;
   logic [IW-1:0] r_idx, r_match_idx, r_free_idx;
   logic        r_found, r_free_found;

   logic        r_t_vld   [2][MAX_ORDERS];
   logic [7:0]  r_t_sym   [2][MAX_ORDERS];
   logic [31:0] r_t_id    [2][MAX_ORDERS];
   logic [31:0] r_t_price [2][MAX_ORDERS];
   logic [31:0] r_t_qty   [2][MAX_ORDERS];

   logic [31:0] r_acc_price, r_acc_qty;
   logic        r_acc_pres;
   logic [31:0] r_best_price [2][NUM_SYMBOLS];
   logic [31:0] r_best_qty   [2][NUM_SYMBOLS];
   logic        r_best_pres  [2][NUM_SYMBOLS];

   logic        r_tob_valid, r_bid_pres, r_ask_pres, r_err_valid;
   logic [7:0]  r_tob_symbol;
   logic [31:0] r_bid_price, r_bid_qty, r_ask_price, r_ask_qty;
   logic [2:0]  r_err_code;

   logic [2:0]  w_in_code, w_apply_code;
   logic [SW-1:0] w_sym;
   logic        w_e_vld, w_e_mine, w_hit, w_better, w_exec_clear, w_apply_clear, w_apply_ok;
   logic [31:0] w_e_price, w_nxt_price, w_nxt_qty;
   logic        w_nxt_pres;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   assign w_sym     = r_sym[SW-1:0];
   assign w_e_vld   = r_t_vld[r_side][r_idx];
   assign w_e_price = r_t_price[r_side][r_idx];
   assign w_e_mine  = w_e_vld && (r_t_sym[r_side][r_idx] == r_sym);
   assign w_hit     = w_e_mine && (r_t_id[r_side][r_idx] == r_id);
   assign w_better  = r_side ? (w_e_price < r_acc_price) : (w_e_price > r_acc_price);
   assign w_exec_clear  = r_qty >= r_t_qty[r_side][r_match_idx];
   assign w_apply_clear = (r_type == MSG_DELETE) || ((r_type == MSG_UPDATE) && (r_qty == 32'd0)) ||
                          ((r_type == MSG_EXECUTE) && w_exec_clear);
   assign w_apply_ok    = (r_state == APPLY) && (w_apply_code == 3'd0);

   always_comb begin
      w_in_code = 3'd0;
      if (parsed_message.symbol >= 8'(NUM_SYMBOLS))
         w_in_code = 3'd4;
      else if (!(parsed_message.msg_type inside {MSG_ADD, MSG_UPDATE, MSG_DELETE, MSG_EXECUTE}))
         w_in_code = 3'd5;
      else if (parsed_message.side > 2'd1)
         w_in_code = 3'd6;
   end

   always_comb begin
      w_apply_code = 3'd0;
      if (r_type == MSG_ADD)
         w_apply_code = r_found ? 3'd1 : (!r_free_found ? 3'd2 : 3'd0);
      else if (!r_found)
         w_apply_code = 3'd3;
   end

   // Running best: strictly better price replaces, equal price accumulates with saturation.
   always_comb begin
      w_nxt_price = r_acc_price;
      w_nxt_qty   = r_acc_qty;
      w_nxt_pres  = r_acc_pres;
      if (w_e_mine) begin
         if (!r_acc_pres || w_better) begin
            w_nxt_price = w_e_price;
            w_nxt_qty   = r_t_qty[r_side][r_idx];
            w_nxt_pres  = 1'b1;
         end else if (w_e_price == r_acc_price) begin
            w_nxt_qty   = sat_add(r_acc_qty, r_t_qty[r_side][r_idx]);
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      read_en = 1'b0;
      case (r_state)
         IDLE: if (reset && !empty && !r_err_valid) begin
            read_en = 1'b1;
            if (w_in_code == 3'd0) w_next = SEARCH;
         end
         SEARCH:  if (r_idx == LAST) w_next = APPLY;
         APPLY:   w_next = (w_apply_code != 3'd0) ? IDLE : REBEST;
         REBEST:  if (r_idx == LAST) w_next = PUBLISH;
         PUBLISH: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign busy = read_en || (r_state != IDLE) || r_err_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_idx <= '0; r_match_idx <= '0; r_free_idx <= '0;
         r_found <= 1'b0; r_free_found <= 1'b0;
         r_acc_price <= '0; r_acc_qty <= '0; r_acc_pres <= 1'b0;
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < MAX_ORDERS; i++) r_t_vld[s][i] <= 1'b0;
            for (int k = 0; k < NUM_SYMBOLS; k++) begin
               r_best_price[s][k] <= '0; r_best_qty[s][k] <= '0; r_best_pres[s][k] <= 1'b0;
            end
         end
         r_tob_valid <= 1'b0; r_tob_symbol <= '0; r_err_valid <= 1'b0; r_err_code <= '0;
         r_bid_price <= '0; r_bid_qty <= '0; r_bid_pres <= 1'b0;
         r_ask_price <= '0; r_ask_qty <= '0; r_ask_pres <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_tob_valid <= 1'b0;
         r_err_valid <= 1'b0;
         case (r_state)
            IDLE: if (read_en) begin
               r_idx <= '0; r_found <= 1'b0; r_free_found <= 1'b0;
               if (w_in_code != 3'd0) begin
                  r_err_valid <= 1'b1; r_err_code <= w_in_code;
               end
            end
            SEARCH: begin
               if (w_hit && !r_found) begin r_found <= 1'b1; r_match_idx <= r_idx; end
               if (!w_e_vld && !r_free_found) begin r_free_found <= 1'b1; r_free_idx <= r_idx; end
               r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end
            APPLY: begin
               r_acc_price <= '0; r_acc_qty <= '0; r_acc_pres <= 1'b0;
               if (w_apply_code != 3'd0) begin
                  r_err_valid <= 1'b1; r_err_code <= w_apply_code;
               end else if (r_type == MSG_ADD)
                  r_t_vld[r_side][r_free_idx] <= 1'b1;
               else if (w_apply_clear)
                  r_t_vld[r_side][r_match_idx] <= 1'b0;
            end
            REBEST: begin
               r_acc_price <= w_nxt_price; r_acc_qty <= w_nxt_qty; r_acc_pres <= w_nxt_pres;
               r_idx <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
               if (r_idx == LAST) begin
                  r_best_price[r_side][w_sym] <= w_nxt_price;
                  r_best_qty[r_side][w_sym]   <= w_nxt_qty;
                  r_best_pres[r_side][w_sym]  <= w_nxt_pres;
                  r_tob_valid <= 1'b1; r_tob_symbol <= r_sym;
                  if (!r_side) begin
                     r_bid_price <= w_nxt_price; r_bid_qty <= w_nxt_qty; r_bid_pres <= w_nxt_pres;
                     r_ask_price <= r_best_price[1][w_sym]; r_ask_qty <= r_best_qty[1][w_sym];
                     r_ask_pres  <= r_best_pres[1][w_sym];
                  end else begin
                     r_ask_price <= w_nxt_price; r_ask_qty <= w_nxt_qty; r_ask_pres <= w_nxt_pres;
                     r_bid_price <= r_best_price[0][w_sym]; r_bid_qty <= r_best_qty[0][w_sym];
                     r_bid_pres  <= r_best_pres[0][w_sym];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Message capture and table payload carry no reset; validity bits above gate them.
   always_ff @(posedge clk) begin
      if (read_en) begin
         r_type  <= parsed_message.msg_type; r_side  <= parsed_message.side[0];
         r_sym   <= parsed_message.symbol;   r_id    <= parsed_message.order_id;
         r_price <= parsed_message.price;    r_qty   <= parsed_message.quantity;
      end
      if (w_apply_ok) begin
         if (r_type == MSG_ADD) begin
            r_t_sym[r_side][r_free_idx]   <= r_sym;   r_t_id[r_side][r_free_idx]  <= r_id;
            r_t_price[r_side][r_free_idx] <= r_price; r_t_qty[r_side][r_free_idx] <= r_qty;
         end else if (r_type == MSG_UPDATE) begin
            r_t_price[r_side][r_match_idx] <= r_price; r_t_qty[r_side][r_match_idx] <= r_qty;
         end else if ((r_type == MSG_EXECUTE) && !w_exec_clear) begin
            r_t_qty[r_side][r_match_idx] <= r_t_qty[r_side][r_match_idx] - r_qty;
         end
      end
   end

`ifdef ORDER_BOOK_STATS_EN
   logic [31:0]   r_msg_count, r_reject_count;
   logic [OW-1:0] r_bid_occ, r_ask_occ;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_msg_count <= '0; r_reject_count <= '0; r_bid_occ <= '0; r_ask_occ <= '0;
      end else begin
         if (read_en) r_msg_count <= r_msg_count + 32'd1;
         if (r_err_valid) r_reject_count <= r_reject_count + 32'd1;
         if (w_apply_ok) begin
            if (r_type == MSG_ADD) begin
               if (r_side) r_ask_occ <= r_ask_occ + 1'b1; else r_bid_occ <= r_bid_occ + 1'b1;
            end else if (w_apply_clear) begin
               if (r_side) r_ask_occ <= r_ask_occ - 1'b1; else r_bid_occ <= r_bid_occ - 1'b1;
            end
         end
      end
   end
   assign msg_count = r_msg_count;  assign reject_count  = r_reject_count;
   assign bid_occupancy = r_bid_occ; assign ask_occupancy = r_ask_occ;
`else
   assign msg_count = '0;     assign reject_count  = '0;
   assign bid_occupancy = '0; assign ask_occupancy = '0;
`endif

   assign tob_valid = r_tob_valid;           assign tob_symbol = r_tob_symbol;
   assign best_bid_price = r_bid_price;      assign best_bid_quantity = r_bid_qty;
   assign best_ask_price = r_ask_price;      assign best_ask_quantity = r_ask_qty;
   assign bid_present = r_bid_pres;          assign ask_present = r_ask_pres;
   assign err_valid = r_err_valid;           assign err_code = r_err_code;
endmodule

// File: tb/tb_multi_symbol_order_book.sv
// Scoreboard bench for multi_symbol_order_book: directed messages push expected publishes/errors, a monitor checks them.
`timescale 1ns/1ps
module tb_multi_symbol_order_book;
   import msob_pkg::*;
   localparam int MAXO = 16;
   localparam int NSYM = 4;
   localparam int LAT  = 2*MAXO + 2;
   localparam int ELAT = MAXO + 2;

   logic clk = 1'b0, reset = 1'b0, empty = 1'b1;
   parsed_msg_t pm;
   logic read_en, busy, tob_valid, bid_present, ask_present, err_valid;
   logic [7:0] tob_symbol;
   logic [31:0] best_bid_price, best_ask_price, best_bid_quantity, best_ask_quantity;
   logic [2:0] err_code;
   logic [31:0] msg_count, reject_count;
   logic [$clog2(MAXO):0] bid_occupancy, ask_occupancy;

   always #5 clk = ~clk;

   multi_symbol_order_book #(.MAX_ORDERS(MAXO), .NUM_SYMBOLS(NSYM)) dut (
      .clk(clk), .reset(reset), .empty(empty), .parsed_message(pm),
      .read_en(read_en), .busy(busy), .tob_valid(tob_valid), .tob_symbol(tob_symbol),
      .best_bid_price(best_bid_price), .best_ask_price(best_ask_price),
      .best_bid_quantity(best_bid_quantity), .best_ask_quantity(best_ask_quantity),
      .bid_present(bid_present), .ask_present(ask_present),
      .err_valid(err_valid), .err_code(err_code),
      .msg_count(msg_count), .reject_count(reject_count),
      .bid_occupancy(bid_occupancy), .ask_occupancy(ask_occupancy));

   typedef struct {
      bit          is_err;
      logic [2:0]  code;
      logic [7:0]  sym;
      logic [31:0] bp, bq, ap, aq;
      bit          bpr, apr;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int n_total = 0, n_bad = 0, cyc = 0, pop_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t et(input logic [7:0] s, input logic [31:0] bp, input logic [31:0] bq, input bit bpr,
                               input logic [31:0] ap, input logic [31:0] aq, input bit apr);
      exp_t e;
      e.is_err = 1'b0; e.code = 3'd0; e.sym = s;
      e.bp = bp; e.bq = bq; e.bpr = bpr; e.ap = ap; e.aq = aq; e.apr = apr; e.lat = LAT;
      return e;
   endfunction

   function automatic exp_t ee(input logic [2:0] c, input int lat);
      exp_t e;
      e = et(8'd0, 0, 0, 1'b0, 0, 0, 1'b0);
      e.is_err = 1'b1; e.code = c; e.lat = lat;
      return e;
   endfunction

   function automatic parsed_msg_t mk(input logic [2:0] t, input logic [1:0] sd, input logic [7:0] s,
                                      input logic [31:0] id, input logic [31:0] p, input logic [31:0] q);
      parsed_msg_t m;
      m.msg_type = t; m.side = sd; m.symbol = s; m.order_id = id; m.price = p; m.quantity = q;
      return m;
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (read_en) pop_cyc = cyc;
      if (tob_valid || err_valid) begin
         if (sb.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL unexpected_output tob_valid=%0b err_valid=%0b required=none", tob_valid, err_valid);
         end else begin
            mon_e = sb.pop_front();
            chk("latency", 32'(cyc - pop_cyc), 32'(mon_e.lat));
            if (mon_e.is_err) begin
               chk("err_valid", 32'(err_valid), 32'd1);
               chk("err_code", 32'(err_code), 32'(mon_e.code));
               chk("tob_valid_on_err", 32'(tob_valid), 32'd0);
            end else begin
               chk("err_valid_on_tob", 32'(err_valid), 32'd0);
               chk("tob_symbol", 32'(tob_symbol), 32'(mon_e.sym));
               chk("bid_price", best_bid_price, mon_e.bp);
               chk("bid_qty", best_bid_quantity, mon_e.bq);
               chk("bid_present", 32'(bid_present), 32'(mon_e.bpr));
               chk("ask_price", best_ask_price, mon_e.ap);
               chk("ask_qty", best_ask_quantity, mon_e.aq);
               chk("ask_present", 32'(ask_present), 32'(mon_e.apr));
            end
         end
      end
   end

   task automatic pop_one(input parsed_msg_t m);
      bit got;
      got = 1'b0;
      pm = m; empty = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (read_en) got = 1'b1;
      end
      if (!got) begin
         n_total++; n_bad++;
         $display("FAIL pop_timeout read_en=0 required=1");
      end
      @(posedge clk); #1;
      empty = 1'b1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_total++; n_bad++;
         $display("FAIL response_timeout pending=%0d required=0", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic send(input parsed_msg_t m, input exp_t e);
      sb.push_back(e);
      pop_one(m);
      wait_done();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_tob_valid"}, 32'(tob_valid), 32'd0);
      chk({tag, "_tob_symbol"}, 32'(tob_symbol), 32'd0);
      chk({tag, "_bid_price"}, best_bid_price, 32'd0);
      chk({tag, "_bid_qty"}, best_bid_quantity, 32'd0);
      chk({tag, "_ask_price"}, best_ask_price, 32'd0);
      chk({tag, "_ask_qty"}, best_ask_quantity, 32'd0);
      chk({tag, "_presents"}, 32'({bid_present, ask_present}), 32'd0);
      chk({tag, "_err"}, 32'({err_valid, err_code}), 32'd0);
      chk({tag, "_read_en"}, 32'(read_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_counts"}, msg_count | reject_count, 32'd0);
      chk({tag, "_occupancy"}, 32'({bid_occupancy, ask_occupancy}), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   localparam logic [1:0] BID = 2'd0, ASK = 2'd1;

   initial begin
      pm = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      send(mk(MSG_ADD, BID, 8'd1, 32'h1111_1111, 32'd1000, 32'd10), et(8'd1, 1000, 10, 1, 0, 0, 0));
      send(mk(MSG_ADD, BID, 8'd1, 32'h2222_2222, 32'd1050, 32'd5),  et(8'd1, 1050, 5, 1, 0, 0, 0));
      send(mk(MSG_ADD, BID, 8'd1, 32'h3333_3333, 32'd990, 32'd20),  et(8'd1, 1050, 5, 1, 0, 0, 0));
      send(mk(MSG_ADD, ASK, 8'd1, 32'hAAAA_AAAA, 32'd1100, 32'd15), et(8'd1, 1050, 5, 1, 1100, 15, 1));
      send(mk(MSG_ADD, ASK, 8'd1, 32'hBBBB_BBBB, 32'd1080, 32'd10), et(8'd1, 1050, 5, 1, 1080, 10, 1));
      send(mk(MSG_ADD, ASK, 8'd1, 32'hCCCC_CCCC, 32'd1150, 32'd5),  et(8'd1, 1050, 5, 1, 1080, 10, 1));
      send(mk(MSG_ADD, ASK, 8'd1, 32'hDDDD_DDDD, 32'd1080, 32'd7),  et(8'd1, 1050, 5, 1, 1080, 17, 1));
      send(mk(MSG_ADD, BID, 8'd2, 32'h1111_1111, 32'd2000, 32'd3),  et(8'd2, 2000, 3, 1, 0, 0, 0));
      send(mk(MSG_ADD, ASK, 8'd2, 32'hAAAA_AAAA, 32'd2100, 32'd4),  et(8'd2, 2000, 3, 1, 2100, 4, 1));
      send(mk(MSG_ADD, BID, 8'd9, 32'h0000_0001, 32'd1, 32'd1), ee(3'd4, 1));
      send(mk(3'd7, BID, 8'd1, 32'h0000_0001, 32'd1, 32'd1), ee(3'd5, 1));
      send(mk(MSG_ADD, 2'd2, 8'd1, 32'h0000_0001, 32'd1, 32'd1), ee(3'd6, 1));
      send(mk(MSG_UPDATE, ASK, 8'd1, 32'hBBBB_BBBB, 32'd1075, 32'd11), et(8'd1, 1050, 5, 1, 1075, 11, 1));
      send(mk(MSG_EXECUTE, ASK, 8'd1, 32'hBBBB_BBBB, 32'd0, 32'd20), et(8'd1, 1050, 5, 1, 1080, 7, 1));
      send(mk(MSG_EXECUTE, ASK, 8'd1, 32'hDDDD_DDDD, 32'd0, 32'd3),  et(8'd1, 1050, 5, 1, 1080, 4, 1));
      send(mk(MSG_DELETE, ASK, 8'd1, 32'h1234_5678, 32'd0, 32'd0), ee(3'd3, ELAT));
      send(mk(MSG_DELETE, BID, 8'd1, 32'h2222_2222, 32'd0, 32'd0), et(8'd1, 1000, 10, 1, 1080, 4, 1));
      send(mk(MSG_UPDATE, ASK, 8'd1, 32'hCCCC_CCCC, 32'd1150, 32'd0), et(8'd1, 1000, 10, 1, 1080, 4, 1));
      send(mk(MSG_UPDATE, ASK, 8'd1, 32'hCCCC_CCCC, 32'd1150, 32'd1), ee(3'd3, ELAT));
      send(mk(MSG_ADD, ASK, 8'd0, 32'd1, 32'd100, 32'hFFFF_FFF0), et(8'd0, 0, 0, 0, 100, 32'hFFFF_FFF0, 1));
      send(mk(MSG_ADD, ASK, 8'd0, 32'd2, 32'd100, 32'h20),        et(8'd0, 0, 0, 0, 100, 32'hFFFF_FFFF, 1));

      // Three bids already rest; thirteen more fill the bid table.
      for (int i = 0; i < 13; i++)
         send(mk(MSG_ADD, BID, 8'd3, 32'h3000_0000 + i, 32'(500 + i), 32'd1),
              et(8'd3, 32'(500 + i), 1, 1, 0, 0, 0));
      send(mk(MSG_ADD, BID, 8'd3, 32'h3000_00FF, 32'd600, 32'd1), ee(3'd2, ELAT));
      send(mk(MSG_ADD, BID, 8'd1, 32'h1111_1111, 32'd1, 32'd1), ee(3'd1, ELAT));
      send(mk(MSG_ADD, ASK, 8'd3, 32'h3000_0000, 32'd700, 32'd2), et(8'd3, 512, 1, 1, 700, 2, 1));
      chk("busy_after_publish", 32'(busy), 32'd0);
`ifdef ORDER_BOOK_STATS_EN
      chk("msg_count", msg_count, 32'd37);
      chk("reject_count", reject_count, 32'd7);
      chk("bid_occupancy", 32'(bid_occupancy), 32'd16);
      chk("ask_occupancy", 32'(ask_occupancy), 32'd6);
`else
      chk("stats_tied", msg_count | reject_count, 32'd0);
      chk("occ_tied", 32'({bid_occupancy, ask_occupancy}), 32'd0);
`endif

      // Reset lands while the next message is in its search scan and must be discarded.
      pop_one(mk(MSG_ADD, BID, 8'd1, 32'h0000_0055, 32'd777, 32'd9));
      repeat (4) @(posedge clk);
      #2;
      chk("busy_mid_search", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk_idle_outputs("midreset");
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      send(mk(MSG_ADD, BID, 8'd1, 32'h0000_0066, 32'd800, 32'd2), et(8'd1, 800, 2, 1, 0, 0, 0));
      send(mk(MSG_ADD, ASK, 8'd3, 32'h0000_0001, 32'd900, 32'd1), et(8'd3, 0, 0, 0, 900, 1, 1));
`ifdef ORDER_BOOK_STATS_EN
      chk("msg_count_post_reset", msg_count, 32'd2);
      chk("reject_count_post_reset", reject_count, 32'd0);
      chk("occ_post_reset", 32'({bid_occupancy, ask_occupancy}), 32'({5'd1, 5'd1}));
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
